vga_vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two requesters: the VGA scanout fetch, which is hard real-time, and the CPU bus, which can be stalled.
- Sits between the 640x480 timing/pixel pipeline, the CPU bus bridge and the VRAM macro.
- Issues at most one RAM access per cycle. Display requests take priority; CPU accesses use a req/ack handshake.

---
 rtl/vga_pkg.sv | 6 +
 rtl/vga_vram_arbiter.sv | 75 +++++++
 tb/tb_vga_vram_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VRAM geometry constants and the arbiter owner tag enum
package vga_pkg;
  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 16;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} owner_e;
endpackage

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: single-port VRAM arbiter, display fetch over CPU bus; optional starve guard via VGA_VRAM_ARB_STARVE_GUARD_EN
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_drop,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  owner_e            own_q, own_d;
  logic              we_q;
  logic [DATA_W-1:0] drd_q, crd_q;
  logic              cpu_busy, force_cpu, disp_iss, cpu_iss;
  if (STARVE_MAX < 1) begin : g_chk
    $error("STARVE_MAX must be at least 1");
  end
  assign cpu_busy = own_q == OWN_CPU;
`ifdef VGA_VRAM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign force_cpu = !rst && cpu_req && !cpu_busy && cnt_q == CW'(STARVE_MAX);
  assign cnt_d = (cpu_iss || !cpu_req) ? '0 :
                 (disp_req && !cpu_busy && cnt_q != CW'(STARVE_MAX)) ? cnt_q + 1'b1 : cnt_q;
  assign disp_drop = disp_req && force_cpu;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  assign force_cpu = 1'b0;
  assign disp_drop = 1'b0;
`endif
  // Reset gates both issue and return so an abandoned access never surfaces.
  assign disp_iss = !rst && disp_req && !force_cpu;
  assign cpu_iss  = !rst && cpu_req && !cpu_busy && !disp_iss;
  always_comb begin
    ram_en     = disp_iss || cpu_iss;
    ram_we     = cpu_iss && cpu_we;
    ram_addr   = disp_iss ? disp_addr : cpu_iss ? cpu_addr : '0;
    ram_wdata  = cpu_iss ? cpu_wdata : '0;
    own_d      = disp_iss ? OWN_DISP : cpu_iss ? OWN_CPU : OWN_NONE;
    disp_valid = !rst && own_q == OWN_DISP;
    cpu_ack    = !rst && own_q == OWN_CPU;
    disp_rdata = disp_valid ? ram_rdata : drd_q;
    cpu_rdata  = (cpu_ack && !we_q) ? ram_rdata : crd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q <= OWN_NONE;
      we_q  <= 1'b0;
      drd_q <= '0;
      crd_q <= '0;
    end else begin
      own_q <= own_d;
      we_q  <= ram_we;
      drd_q <= disp_rdata;
      crd_q <= cpu_rdata;
    end
  end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed stimulus with a transaction-level model checked every cycle
module tb_vga_vram_arbiter;
  localparam int AW = 15, DW = 16, SMAX = 8, MEM_N = 1 << AW;
  logic clk = 0, rst = 1;
  logic disp_req = 0, cpu_req = 0, cpu_we = 0;
  logic [AW-1:0] disp_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ram_rdata = '0;
  logic disp_valid, disp_drop, cpu_ack, ram_en, ram_we;
  logic [DW-1:0] disp_rdata, cpu_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  int checks = 0, errors = 0, dv_cnt = 0, drop_cnt = 0;
  logic [DW-1:0] env_mem [MEM_N];
  logic [DW-1:0] m_mem [MEM_N];
  int m_ret = 0, m_starve = 0;
  logic m_ret_we = 0;
  logic [DW-1:0] m_ret_data = '0, m_dhold = '0, m_chold = '0;

  vga_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_rdata(disp_rdata), .disp_drop(disp_drop),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) begin
      env_mem[i] = DW'(i);
      m_mem[i] = DW'(i);
    end
  end

  // synchronous RAM environment, one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) env_mem[ram_addr] <= ram_wdata;
      else ram_rdata <= env_mem[ram_addr];
    end
  end

  // model: 0 = nothing returns next cycle, 1 = display read returns, 2 = CPU access returns
  always @(negedge clk) begin
    logic e_dv, e_ack, cpu_ok, starve_win, d_iss, c_iss, e_drop;
    logic [DW-1:0] e_drd, e_crd;
    e_dv  = !rst && m_ret == 1;
    e_ack = !rst && m_ret == 2;
    e_drd = e_dv ? m_ret_data : m_dhold;
    e_crd = (e_ack && !m_ret_we) ? m_ret_data : m_chold;
    cpu_ok = !rst && cpu_req && m_ret != 2;
`ifdef VGA_VRAM_ARB_STARVE_GUARD_EN
    starve_win = cpu_ok && m_starve == SMAX;
`else
    starve_win = 1'b0;
`endif
    d_iss  = !rst && disp_req && !starve_win;
    c_iss  = cpu_ok && !d_iss;
    e_drop = !rst && disp_req && starve_win;
    chk("ram_en", ram_en, d_iss || c_iss);
    chk("ram_we", ram_we, c_iss && cpu_we);
    chk("ram_addr", ram_addr, d_iss ? disp_addr : c_iss ? cpu_addr : '0);
    chk("ram_wdata", ram_wdata, c_iss ? cpu_wdata : '0);
    chk("disp_valid", disp_valid, e_dv);
    chk("disp_rdata", disp_rdata, e_drd);
    chk("cpu_ack", cpu_ack, e_ack);
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("disp_drop", disp_drop, e_drop);
    dv_cnt += int'(disp_valid);
    drop_cnt += int'(disp_drop);
    if (rst) begin
      m_ret = 0; m_ret_we = 0; m_starve = 0; m_dhold = '0; m_chold = '0;
    end else begin
      m_dhold = e_drd;
      m_chold = e_crd;
      m_ret = d_iss ? 1 : c_iss ? 2 : 0;
      m_ret_we = c_iss && cpu_we;
      if (d_iss) m_ret_data = m_mem[disp_addr];
      else if (c_iss && !cpu_we) m_ret_data = m_mem[cpu_addr];
      if (c_iss && cpu_we) m_mem[cpu_addr] = cpu_wdata;
      if (c_iss || !cpu_req) m_starve = 0;
      else if (cpu_ok && disp_req && m_starve < SMAX) m_starve++;
    end
  end

  // holds the request through the ack cycle; lat = cycles before the ack cycle
  task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output int lat, output logic [DW-1:0] rd);
    bit done = 0;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    lat = 0; rd = '0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        done = 1;
        rd = cpu_rdata;
      end else lat++;
      @(posedge clk); #1;
    end
    if (!done) chk("cpu_timeout", 32'd0, 32'd1);
    cpu_req = 0; cpu_we = 0;
  endtask

  initial begin
    int lat, d0, r0;
    logic [DW-1:0] rd;
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0, r0;
    logic [DW-1:0] rd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", disp_valid, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_ram_en", ram_en, 0);
    @(posedge clk); #1 rst = 0;
    // uncontended write then read
    cpu_xfer(1, 15'h0100, 16'h1234, lat, rd);
    chk("wr_lat", lat, 1);
    cpu_xfer(0, 15'h0100, 16'h0, lat, rd);
    chk("rd_lat", lat, 1);
    chk("rd_data", rd, 16'h1234);
    // 20 back-to-back display fetches
    for (int i = 0; i <= 20; i++) begin
      disp_req = i < 20; disp_addr = AW'(i);
      @(negedge clk);
      chk("burst_valid", disp_valid, i > 0);
      if (i > 0) chk("burst_data", disp_rdata, i - 1);
      @(posedge clk); #1;
    end
    disp_req = 0;
    // CPU read contending with 3 display fetches
    d0 = dv_cnt;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          disp_req = 1; disp_addr = AW'(40 + i);
          @(posedge clk); #1;
        end
        disp_req = 0;
      end
      cpu_xfer(0, 15'h0100, 16'h0, lat, rd);
    join
    chk("cont_lat", lat, 4);
    chk("cont_data", rd, 16'h1234);
    chk("cont_dv", dv_cnt - d0, 3);
    // reset while a CPU read is in flight
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0100;
    @(negedge clk);
    chk("pre_rst_en", ram_en, 1);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("mid_rst_ack", cpu_ack, 0);
    @(posedge clk); #1 rst = 0; cpu_req = 0;
    @(negedge clk);
    chk("post_rst_ack", cpu_ack, 0);
    chk("post_rst_valid", disp_valid, 0);
    chk("post_rst_rdata", cpu_rdata, 0);
    @(posedge clk); #1;
    cpu_xfer(0, 15'h0100, 16'h0, lat, rd);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_data", rd, 16'h1234);
    // sustained display traffic against a pending CPU read
    d0 = dv_cnt; r0 = drop_cnt;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          disp_req = 1; disp_addr = AW'(i % 32);
          @(posedge clk); #1;
        end
        disp_req = 0;
      end
      cpu_xfer(0, 15'h0005, 16'h0, lat, rd);
    join
    repeat (2) @(posedge clk);
    #1;
    chk("starve_data", rd, 16'h0005);
`ifdef VGA_VRAM_ARB_STARVE_GUARD_EN
    chk("starve_lat", lat, 9);
    chk("starve_drop", drop_cnt - r0, 1);
    chk("starve_dv", dv_cnt - d0, 99);
`else
    chk("starve_lat", lat, 101);
    chk("starve_drop", drop_cnt - r0, 0);
    chk("starve_dv", dv_cnt - d0, 100);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
